// File: rtl/result_beat_packer_pkg.sv
// Shared stream-packing definitions: default widths, FSM state type and
// the lanes-filled to byte-strobe mapping.
package mm_stream_pkg;

    localparam int ELEM_W_DEF = 16;
    localparam int BEAT_W_DEF = 128;
    localparam int LANES_DEF  = BEAT_W_DEF / ELEM_W_DEF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // One strobe bit: set when its byte lies inside the filled lanes.
    function automatic logic strb_bit(input int byte_idx, input int lanes_filled, input int lane_bytes);
        return byte_idx < (lanes_filled * lane_bytes);
    endfunction

endpackage

// File: rtl/result_beat_packer_beat_out_reg.sv
// Single-entry valid/ready output register holding {data, strb, last};
// contents stay stable while valid is high and ready is low.
module beat_out_reg #(
    parameter int BEAT_W = 128,
    parameter int STRB_W = BEAT_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [BEAT_W-1:0] i_data,
    input  logic [STRB_W-1:0] i_strb,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [BEAT_W-1:0] o_data,
    output logic [STRB_W-1:0] o_strb,
    output logic              o_last
);

    logic              r_valid;
    logic [BEAT_W-1:0] r_data;
    logic [STRB_W-1:0] r_strb;
    logic              r_last;

    // The packer only loads when the slot is empty or draining this cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_strb  <= '0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_strb  <= i_strb;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_strb  = r_strb;
    assign o_last  = r_last;

endmodule

// File: rtl/result_beat_packer.sv
// Packs ELEM_W result elements into BEAT_W stream beats with byte strobes
// and a last flag; a transfer is a fixed element count given at start.
module result_beat_packer
    import mm_stream_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int BEAT_W = BEAT_W_DEF,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    elem_count,
    output logic                busy,
    output logic                done,
    input  logic                e_valid,
    output logic                e_ready,
    input  logic [ELEM_W-1:0]   e_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [BEAT_W-1:0]   m_data,
    output logic [BEAT_W/8-1:0] m_strb,
    output logic                m_last
);

    localparam int LANES      = BEAT_W / ELEM_W;
    localparam int STRB_W     = BEAT_W / 8;
    localparam int LANE_BYTES = ELEM_W / 8;
    localparam int LANE_W     = (LANES > 1) ? $clog2(LANES) : 1;

    state_t              r_state;
    state_t              w_state_next;
    logic                r_busy;
    logic                r_done;
    logic [LANE_W-1:0]   r_lane;
    logic [CNT_W-1:0]    r_remaining;
    logic [BEAT_W-1:0]   r_acc;

    logic                w_start_go;
    logic                w_start_zero;
    logic                w_lane_full;
    logic                w_final;
    logic                w_completing;
    logic                w_out_free;
    logic                w_e_hs;
    logic                w_load;
    logic                w_beat_hs;
    logic [BEAT_W-1:0]   w_beat_data;
    logic [STRB_W-1:0]   w_strb;

    assign w_start_go   = (r_state == IDLE) && start && (elem_count != '0);
    assign w_start_zero = (r_state == IDLE) && start && (elem_count == '0);
    assign w_lane_full  = (r_lane == LANE_W'(LANES - 1));
    assign w_final      = (r_remaining == CNT_W'(1));
    assign w_completing = w_lane_full || w_final;
    assign w_out_free   = !m_valid || m_ready;
    assign w_e_hs       = e_valid && e_ready;
    assign w_load       = w_e_hs && w_completing;
    assign w_beat_hs    = m_valid && m_ready && m_last;

    // Current element overlays its lane; lanes above r_lane are still zero.
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        assign w_beat_data[gi*ELEM_W +: ELEM_W] =
            (r_lane == LANE_W'(gi)) ? e_data : r_acc[gi*ELEM_W +: ELEM_W];
    end

    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_strb
        assign w_strb[gi] = strb_bit(gi, int'(r_lane) + 1, LANE_BYTES);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != IDLE);
            r_done  <= w_start_zero || ((r_state == DRAIN) && w_beat_hs);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_start_go) w_state_next = PACK;
            PACK:    if (w_e_hs && w_final) w_state_next = DRAIN;
            DRAIN:   if (w_beat_hs) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        e_ready = (r_state == PACK) && (!w_completing || w_out_free);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lane      <= '0;
            r_remaining <= '0;
            r_acc       <= '0;
        end else if (w_start_go) begin
            r_lane      <= '0;
            r_remaining <= elem_count;
            r_acc       <= '0;
        end else if (w_e_hs) begin
            r_remaining <= r_remaining - CNT_W'(1);
            if (w_completing) begin
                r_lane <= '0;
                r_acc  <= '0;
            end else begin
                r_lane <= r_lane + LANE_W'(1);
                r_acc  <= w_beat_data;
            end
        end
    end

    beat_out_reg #(
        .BEAT_W (BEAT_W),
        .STRB_W (STRB_W)
    ) u_out (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_data  (w_beat_data),
        .i_strb  (w_strb),
        .i_last  (w_final),
        .i_ready (m_ready),
        .o_valid (m_valid),
        .o_data  (m_data),
        .o_strb  (m_strb),
        .o_last  (m_last)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: doc/result_beat_packer.md
# result_beat_packer

Packs the scalar result elements of the matrix engine (one ELEM_W word per handshake) into BEAT_W-wide stream beats with byte strobes and a last flag. It sits directly upstream of the Avalon-MM writer and drives that block's s_valid/s_ready/s_data/s_strb/s_last stream. A transfer is a fixed element count supplied at start. A partial final beat carries a reduced strobe.

## Interface
- ELEM_W, 16: element width in bits; multiple of 8, divides BEAT_W.
- BEAT_W, 128: output beat width; LANES = BEAT_W/ELEM_W (8 by default).
- CNT_W, 16: width of the element count.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- elem_count  in  CNT_W  elements in this transfer; sampled with start.
- busy  out  1  high while a transfer is in progress.
- done  out  1  one-cycle completion pulse.
- e_valid  in  1  element valid.
- e_ready  out  1  element accepted when e_valid && e_ready.
- e_data  in  ELEM_W  element value.
- m_valid  out  1  beat valid; feeds writer s_valid.
- m_ready  in  1  downstream ready; fed by writer s_ready.
- m_data  out  BEAT_W  packed beat.
- m_strb  out  BEAT_W/8  byte enables.
- m_last  out  1  marks the final beat of the transfer.

## Operation
- States: IDLE, PACK, DRAIN. busy = (state != IDLE).
- IDLE, start, elem_count>0: latch remaining = elem_count, clear lane index and accumulator, go to PACK.
- IDLE, start, elem_count==0: stay in IDLE, emit no beats, pulse done on the next cycle.
- start outside IDLE is ignored.
- Lane placement: the k-th accepted element of a beat goes to m_data[k*ELEM_W +: ELEM_W]. Lane 0 occupies the LSBs.
- Completing element: an element that fills lane LANES-1, or the final element of the transfer (remaining==1).
- out_free = !m_valid || m_ready.
- e_ready = (state==PACK) && (!completing || out_free). A non-completing element is never stalled.
- On a completing handshake, accumulator plus the element load the output register, and the accumulator and lane index clear.
  - m_strb: the low (lanes_filled*ELEM_W/8) bits are set.
  - Unfilled lanes read as zero.
  - m_last = 1 if this was the final element.
- Final element accepted: go to DRAIN.
- DRAIN: on m_valid && m_ready && m_last, go to IDLE and pulse done on the next cycle.
- The output register holds data/strb/last stable while m_valid && !m_ready.
- remaining decrements by 1 per element handshake. Count arithmetic is unsigned CNT_W and never wraps, because completion ends intake.
- Reset in any state: everything clears and a partial beat is discarded.

## Timing
- Reset values: busy=0, done=0, e_ready=0, m_valid=0, m_data=0, m_strb=0, m_last=0.
- busy rises the cycle after start.
- Beat latency: m_valid rises the cycle after the completing element handshake.
- Throughput: one element per cycle with m_ready held high, so a full beat every LANES cycles.
- When a beat handshakes in the same cycle a completing element arrives, the new beat loads with no bubble.
- done: exactly one cycle, the cycle after the final beat handshake. busy is 0 in the same cycle.
- With elem_count==0, done appears one cycle after start.
- All outputs are registered except e_ready, which is combinational from state, lane, remaining, m_valid and m_ready.

## Structure
- Shared package mm_stream_pkg holds:
  - ELEM_W, BEAT_W and LANES defaults;
  - the state enum typedef (IDLE, PACK, DRAIN);
  - a function mapping lanes_filled to the strobe mask.
- Optional sub-module beat_out_reg: a single-entry valid/ready output register holding {data, strb, last}. Everything else is a flat FSM plus accumulator.

## Test plan
- elem_count=16, e_data=1..16 back-to-back, m_ready=1 -> expect 2 beats.
  - Beat 0: m_data=0x0008_0007_..._0001, m_strb=0xFFFF, m_last=0.
  - Beat 1: lanes 9..16, m_last=1.
  - done one cycle after the beat 1 handshake.
- elem_count=10 -> final beat m_data=0x...0000_000A_0009 (upper lanes zero), m_strb=0x000F, m_last=1, with 2 beats total.
- elem_count=40, m_ready pattern 3 cycles high / 1 cycle low, e_valid random ->
  - 5 beats in order, no loss or duplication;
  - m_data stable during stalls;
  - e_ready low only on completing elements while the output register is occupied.
- elem_count=0 with start -> no m_valid ever, done one cycle after start, busy stays 0.
- Reset asserted after 3 of 8 elements, then start with elem_count=8 and values 0x11..0x18 -> single beat with m_strb=0xFFFF and no stale lanes.
- start pulsed while busy with elem_count=8 -> ignored; the original transfer completes unchanged and exactly one done pulse occurs.
